vx_ecc_rmw_merge: RTL and testbench

Write-side merge stage that sits directly upstream of the Hamming encoder on the ECC-protected memory path. It accepts byte-masked write requests; full-word writes pass straight to the encoder. Partial writes trigger a read of the stored word, take the already-decoded read data, merge the enabled bytes, and send the full merged word to the encoder for write-back. It aborts the write-back when the read returns an uncorrectable error.

---
 rtl/vx_ecc_rmw_merge.sv | 219 +++++++++++++++++++++
 tb/tb_vx_ecc_rmw_merge.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_ecc_rmw_merge.sv
// ----------------------------------------------------------------------------
// vx_ecc_rmw_merge
//
// Write-side merge stage in front of the Hamming encoder on the ECC memory
// path. Full-word writes go straight to the encoder. Partial writes first
// read the stored word, then take the corrected data from the decoder. The
// enabled request bytes are merged over that data, and the full word is sent
// to the encoder. If the read comes back uncorrectable, the write-back is
// dropped and an error event is logged instead.
//
// Ports
//   clk, reset_n           clock, async active-low reset
//   req_valid/req_ready    write request handshake (accepted only in IDLE)
//   req_addr/data/byteen   request word address, data, per-byte enables
//   rd_valid/rd_ready      read request to memory, rd_addr = target word
//   rsp_valid/data/uncorr  decoded read response (single-cycle pulse)
//   wr_valid/wr_ready      merged word to encoder, wr_addr / wr_data
//   err_valid              one-cycle pulse per aborted read-modify-write
//   err_addr               address of the most recent abort (held)
//   err_count              saturating abort count
//   busy                   FSM not idle
//
// States
//   IDLE    | waiting for a request; req_ready high
//   RD_REQ  | read of the stored word presented to memory
//   RD_WAIT | waiting for the decoded read response
//   WR      | merged or full word presented to the encoder
// ----------------------------------------------------------------------------
module vx_ecc_rmw_merge #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 10,
    parameter int BE_BITS   = DATA_BITS / 8
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_data,
    input  logic [BE_BITS-1:0]   req_byteen,

    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [ADDR_BITS-1:0] rd_addr,

    input  logic                 rsp_valid,
    input  logic [DATA_BITS-1:0] rsp_data,
    input  logic                 rsp_uncorr,

    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [DATA_BITS-1:0] wr_data,

    output logic                 err_valid,
    output logic [ADDR_BITS-1:0] err_addr,
    output logic [7:0]           err_count,
    output logic                 busy
);

    if ((DATA_BITS % 8) != 0 || BE_BITS != DATA_BITS / 8) begin : g_param_check
        $error("vx_ecc_rmw_merge: DATA_BITS must be a multiple of 8 and BE_BITS = DATA_BITS/8");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR      = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Latched request
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [BE_BITS-1:0]   be_q, be_d;

    // Registered outputs
    logic                 rd_valid_q, rd_valid_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
    logic                 err_valid_q, err_valid_d;
    logic [ADDR_BITS-1:0] err_addr_q, err_addr_d;
    logic [7:0]           err_count_q, err_count_d;

    logic                 be_full;
    logic                 be_none;
    logic [DATA_BITS-1:0] merged;

    assign be_full = &req_byteen;
    assign be_none = ~|req_byteen;

    // Enabled request bytes override the corrected read data.
    always_comb begin
        merged = rsp_data;
        for (int i = 0; i < BE_BITS; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = data_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        be_d        = be_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        err_valid_d = 1'b0;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    data_d = req_data;
                    be_d   = req_byteen;
                    if (be_full) begin
                        state_d   = WR;
                        wr_addr_d = req_addr;
                        wr_data_d = req_data;
                    end else if (!be_none) begin
                        state_d   = RD_REQ;
                        rd_addr_d = req_addr;
                    end
                    // All-zero enables: accepted and dropped.
                end
            end

            RD_REQ: begin
                // A response arriving during the read handshake is not ours.
                if (rd_ready) begin
                    state_d = RD_WAIT;
                end
            end

            RD_WAIT: begin
                if (rsp_valid) begin
                    if (rsp_uncorr) begin
                        state_d     = IDLE;
                        err_valid_d = 1'b1;
                        err_addr_d  = addr_q;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                    end else begin
                        state_d   = WR;
                        wr_addr_d = addr_q;
                        wr_data_d = merged;
                    end
                end
            end

            WR: begin
                if (wr_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake valids are registered copies of the next state so they
        // line up with the state register without a combinational path.
        rd_valid_d = (state_d == RD_REQ);
        wr_valid_d = (state_d == WR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            be_q        <= '0;
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            be_q        <= be_d;
            rd_valid_q  <= rd_valid_d;
            rd_addr_q   <= rd_addr_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rd_valid  = rd_valid_q;
    assign rd_addr   = rd_addr_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_vx_ecc_rmw_merge.sv
// ----------------------------------------------------------------------------
// tb_vx_ecc_rmw_merge
//
// Self-checking bench for vx_ecc_rmw_merge. Expected reads, writes and error
// events are queued when stimulus is driven; a negedge monitor pops and
// compares them as the DUT produces handshakes. Cycle-accurate timing points
// are checked inline by the stimulus tasks.
// ----------------------------------------------------------------------------
module tb_vx_ecc_rmw_merge;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [BW-1:0] req_byteen;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_uncorr;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          err_valid;
    logic [AW-1:0] err_addr;
    logic [7:0]    err_count;
    logic          busy;

    vx_ecc_rmw_merge #(
        .DATA_BITS (DW),
        .ADDR_BITS (AW)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_byteen (req_byteen),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_uncorr (rsp_uncorr),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .err_valid  (err_valid),
        .err_addr   (err_addr),
        .err_count  (err_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           wr_q[$];
    logic [AW-1:0] rd_q[$];
    logic [AW-1:0] err_q[$];

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_err_cnt = 8'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] d, input logic [DW-1:0] r,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] m;
        m = r;
        for (int i = 0; i < BW; i++) begin
            if (be[i]) m[8*i +: 8] = d[8*i +: 8];
        end
        return m;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset_n) begin
            if (wr_valid && wr_ready) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", {63'd0, wr_valid}, 64'd0);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("sb_wr_addr", {54'd0, wr_addr}, {54'd0, e.addr});
                    chk("sb_wr_data", {32'd0, wr_data}, {32'd0, e.data});
                end
            end
            if (rd_valid && rd_ready) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", {63'd0, rd_valid}, 64'd0);
                end else begin
                    logic [AW-1:0] a;
                    a = rd_q.pop_front();
                    chk("sb_rd_addr", {54'd0, rd_addr}, {54'd0, a});
                end
            end
            if (err_valid) begin
                chk("err_with_wr", {63'd0, wr_valid}, 64'd0);
                if (err_q.size() == 0) begin
                    chk("err_unexpected", {63'd0, err_valid}, 64'd0);
                end else begin
                    logic [AW-1:0] a;
                    a = err_q.pop_front();
                    chk("sb_err_addr", {54'd0, err_addr}, {54'd0, a});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rd_valid"},  {63'd0, rd_valid},  64'd0);
        chk({tag, "_wr_valid"},  {63'd0, wr_valid},  64'd0);
        chk({tag, "_err_valid"}, {63'd0, err_valid}, 64'd0);
        chk({tag, "_rd_addr"},   {54'd0, rd_addr},   64'd0);
        chk({tag, "_wr_addr"},   {54'd0, wr_addr},   64'd0);
        chk({tag, "_wr_data"},   {32'd0, wr_data},   64'd0);
        chk({tag, "_err_addr"},  {54'd0, err_addr},  64'd0);
        chk({tag, "_err_count"}, {56'd0, err_count}, 64'd0);
        chk({tag, "_busy"},      {63'd0, busy},      64'd0);
    endtask

    task automatic send_req(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid  = 1'b1;
        req_addr   = a;
        req_data   = d;
        req_byteen = be;
        step();
        req_valid  = 1'b0;
        req_data   = $urandom;
        req_byteen = BW'($urandom);
    endtask

    // Called in the first WR cycle; wr_ready is low if stall > 0.
    task automatic finish_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int stall);
        chk("wr_valid_first", {63'd0, wr_valid}, 64'd1);
        chk("wr_addr_first",  {54'd0, wr_addr},  {54'd0, a});
        chk("wr_data_first",  {32'd0, wr_data},  {32'd0, d});
        chk("rd_valid_in_wr", {63'd0, rd_valid}, 64'd0);
        chk("req_ready_wr",   {63'd0, req_ready}, 64'd0);
        for (int i = 0; i < stall; i++) begin
            step();
            chk("wr_valid_hold",  {63'd0, wr_valid},  64'd1);
            chk("wr_addr_hold",   {54'd0, wr_addr},   {54'd0, a});
            chk("wr_data_hold",   {32'd0, wr_data},   {32'd0, d});
            chk("req_ready_hold", {63'd0, req_ready}, 64'd0);
        end
        wr_ready = 1'b1;
        step();
        chk("wr_valid_done",  {63'd0, wr_valid},  64'd0);
        chk("req_ready_done", {63'd0, req_ready}, 64'd1);
    endtask

    task automatic full_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int wr_stall);
        wr_t e;
        e.addr = a;
        e.data = d;
        wr_q.push_back(e);
        if (wr_stall > 0) wr_ready = 1'b0;
        send_req(a, d, {BW{1'b1}});
        finish_wr(a, d, wr_stall);
    endtask

    task automatic partial(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be,
                           input int rd_stall, input logic [DW-1:0] rsp, input logic unc,
                           input int rsp_delay, input int wr_stall, input logic junk_rsp);
        logic [DW-1:0] m;
        rd_q.push_back(a);
        if (rd_stall > 0) rd_ready = 1'b0;
        send_req(a, d, be);
        chk("rd_valid_n1",  {63'd0, rd_valid},  64'd1);
        chk("rd_addr_n1",   {54'd0, rd_addr},   {54'd0, a});
        chk("busy_rd",      {63'd0, busy},      64'd1);
        chk("req_ready_rd", {63'd0, req_ready}, 64'd0);
        for (int i = 0; i < rd_stall; i++) begin
            step();
            chk("rd_valid_hold",    {63'd0, rd_valid},  64'd1);
            chk("rd_addr_hold",     {54'd0, rd_addr},   {54'd0, a});
            chk("req_ready_rdhold", {63'd0, req_ready}, 64'd0);
        end
        rd_ready = 1'b1;
        if (junk_rsp) begin
            rsp_valid  = 1'b1;
            rsp_uncorr = 1'b1;
            rsp_data   = $urandom;
        end
        step();
        rsp_valid  = 1'b0;
        rsp_uncorr = 1'b0;
        chk("rd_valid_wait", {63'd0, rd_valid}, 64'd0);
        chk("busy_wait",     {63'd0, busy},     64'd1);
        for (int i = 0; i < rsp_delay; i++) begin
            step();
            chk("wr_valid_wait",  {63'd0, wr_valid},  64'd0);
            chk("err_valid_wait", {63'd0, err_valid}, 64'd0);
        end
        if (wr_stall > 0) wr_ready = 1'b0;
        m          = merge(d, rsp, be);
        rsp_valid  = 1'b1;
        rsp_data   = rsp;
        rsp_uncorr = unc;
        if (unc) begin
            err_q.push_back(a);
            if (exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'd1;
        end else begin
            wr_t e;
            e.addr = a;
            e.data = m;
            wr_q.push_back(e);
        end
        step();
        rsp_valid  = 1'b0;
        rsp_uncorr = 1'b0;
        rsp_data   = $urandom;
        if (unc) begin
            chk("err_valid_m1",  {63'd0, err_valid}, 64'd1);
            chk("wr_valid_abrt", {63'd0, wr_valid},  64'd0);
            chk("req_ready_m1",  {63'd0, req_ready}, 64'd1);
            chk("err_addr_m1",   {54'd0, err_addr},  {54'd0, a});
            chk("err_count_m1",  {56'd0, err_count}, {56'd0, exp_err_cnt});
            wr_ready = 1'b1;
            step();
            chk("err_valid_m2",  {63'd0, err_valid}, 64'd0);
            chk("wr_valid_m2",   {63'd0, wr_valid},  64'd0);
        end else begin
            finish_wr(a, m, wr_stall);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        req_byteen = '0;
        rd_ready   = 1'b1;
        rsp_valid  = 1'b0;
        rsp_data   = '0;
        rsp_uncorr = 1'b0;
        wr_ready   = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset_n = 1'b1;
        step();
        chk("req_ready_after_rst", {63'd0, req_ready}, 64'd1);

        // Full write
        full_write(10'h005, 32'hDEADBEEF, 0);

        // Partial merge: 0xAABBCCDD over 0x11223344 with bytes 0 and 2 -> 0x11BB33DD
        partial(10'h010, 32'hAABBCCDD, 4'b0101, 0, 32'h11223344, 1'b0, 2, 0, 1'b0);

        // Uncorrectable abort
        partial(10'h3FF, 32'h12345678, 4'b0011, 0, 32'h0BADF00D, 1'b1, 1, 0, 1'b0);

        // Backpressure on both handshakes, plus a response during the read handshake
        full_write(10'h123, 32'hCAFEF00D, 5);
        partial(10'h0AA, 32'h55667788, 4'b1110, 3, 32'h99AABBCC, 1'b0, 0, 5, 1'b1);

        // byteen = 0 is a no-op
        send_req(10'h077, 32'hFFFFFFFF, 4'b0000);
        chk("be0_req_ready", {63'd0, req_ready}, 64'd1);
        chk("be0_busy",      {63'd0, busy},      64'd0);
        chk("be0_rd_valid",  {63'd0, rd_valid},  64'd0);
        chk("be0_wr_valid",  {63'd0, wr_valid},  64'd0);
        step();
        chk("be0_rd_valid2", {63'd0, rd_valid},  64'd0);
        chk("be0_wr_valid2", {63'd0, wr_valid},  64'd0);

        // Stray response in IDLE
        rsp_valid  = 1'b1;
        rsp_uncorr = 1'b1;
        rsp_data   = 32'h0;
        step();
        rsp_valid  = 1'b0;
        rsp_uncorr = 1'b0;
        chk("stray_busy",      {63'd0, busy},      64'd0);
        chk("stray_err_valid", {63'd0, err_valid}, 64'd0);
        chk("stray_wr_valid",  {63'd0, wr_valid},  64'd0);
        chk("stray_err_count", {56'd0, err_count}, {56'd0, exp_err_cnt});

        // Mixed random traffic
        for (int i = 0; i < 12; i++) begin
            logic [BW-1:0] be;
            be = BW'($urandom);
            if (be == '0) be = 4'b1000;
            if (be == {BW{1'b1}})
                full_write(AW'($urandom), $urandom, $urandom_range(0, 2));
            else
                partial(AW'($urandom), $urandom, be, $urandom_range(0, 2), $urandom,
                        1'b0, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
        end

        // Saturation: 256 more aborts
        for (int i = 0; i < 256; i++) begin
            partial(AW'($urandom), $urandom, 4'b0001, 0, $urandom, 1'b1, 0, 0, 1'b0);
        end
        chk("err_count_sat", {56'd0, err_count}, 64'd255);

        // Reset while in RD_WAIT, then a late response
        rd_q.push_back(10'h02A);
        send_req(10'h02A, 32'h01020304, 4'b0110);
        step();
        chk("mid_busy_wait", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        step();
        reset_n = 1'b1;
        exp_err_cnt = 8'd0;
        step();
        rsp_valid  = 1'b1;
        rsp_uncorr = 1'b0;
        rsp_data   = 32'hA5A5A5A5;
        step();
        rsp_valid  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_rsp_wr_valid", {63'd0, wr_valid}, 64'd0);
            chk("late_rsp_busy",     {63'd0, busy},     64'd0);
            step();
        end

        // Traffic resumes normally after reset
        full_write(10'h200, 32'h0F0F0F0F, 0);
        partial(10'h201, 32'hFFEEDDCC, 4'b1001, 0, 32'h00112233, 1'b0, 1, 0, 1'b0);

        step();
        chk("wr_q_empty",  64'(wr_q.size()),  64'd0);
        chk("rd_q_empty",  64'(rd_q.size()),  64'd0);
        chk("err_q_empty", 64'(err_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
